// File: rtl/rv32i_types.sv
// Shared core types; this slice adds the physical-memory burst bridge state
// and its line geometry constants.
package rv32i_types;

    localparam int PMEM_BURST_LEN = 4;
    localparam int PMEM_BEAT_W    = 64;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RD_FETCH   = 3'd1,
        RD_RESP    = 3'd2,
        DONE       = 3'd3,
        WR_COLLECT = 3'd4,
        WR_DRAIN   = 3'd5
    } pmem_bridge_state_t;

    // 64-bit backing word address of word idx within a 32-byte line.
    function automatic logic [28:0] pmem_word_addr(input logic [26:0] line,
                                                   input logic [1:0]  idx);
        return {line, idx};
    endfunction

endpackage

// File: rtl/burst_line_buffer.sv
// One cacheline of storage: four 64-bit words, one synchronous write port and
// one combinational read port. Contents are don't-care after reset.
module burst_line_buffer
    import rv32i_types::*;
(
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [1:0]             wr_idx,
    input  logic [PMEM_BEAT_W-1:0] wr_data,
    input  logic [1:0]             rd_idx,
    output logic [PMEM_BEAT_W-1:0] rd_data
);

    logic [PMEM_BEAT_W-1:0] mem_q [PMEM_BURST_LEN];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/pmem_burst_bridge.sv
// Converts 4-beat pmem bursts into single-word req/gnt/rvalid backing
// transactions, buffering a whole line so pmem_resp beats are always back to back.
module pmem_burst_bridge
    import rv32i_types::*;
#(
    parameter int BURST_LEN = PMEM_BURST_LEN
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   pmem_read,
    input  logic                   pmem_write,
    input  logic [31:0]            pmem_address,
    input  logic [PMEM_BEAT_W-1:0] pmem_wdata,
    output logic                   pmem_resp,
    output logic [PMEM_BEAT_W-1:0] pmem_rdata,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [28:0]            mem_addr,
    output logic [PMEM_BEAT_W-1:0] mem_wdata,
    input  logic                   mem_gnt,
    input  logic                   mem_rvalid,
    input  logic [PMEM_BEAT_W-1:0] mem_rdata,
    output pmem_bridge_state_t     dbg_state
);

    // Backing handshake: a word moves when mem_req & mem_gnt at a rising edge;
    // mem_req/addr/we/wdata stay put while stalled. mem_rvalid is never stalled.
    localparam logic [2:0] LINE_WORDS = 3'(BURST_LEN);

    pmem_bridge_state_t state_q, state_d;
    logic [26:0] line_q, line_d;
    logic [2:0]  issued_q, issued_d;
    logic [2:0]  recvd_q, recvd_d;
    logic [1:0]  beat_q, beat_d;

    logic                   buf_we;
    logic [1:0]             buf_widx;
    logic [PMEM_BEAT_W-1:0] buf_wdata;
    logic [1:0]             buf_ridx;
    logic [PMEM_BEAT_W-1:0] buf_rdata;

    logic unused_addr_bits;
    assign unused_addr_bits = ^pmem_address[4:0];

    burst_line_buffer u_buf (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_idx  (buf_widx),
        .wr_data (buf_wdata),
        .rd_idx  (buf_ridx),
        .rd_data (buf_rdata)
    );

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        issued_d   = issued_q;
        recvd_d    = recvd_q;
        beat_d     = beat_q;
        buf_we     = 1'b0;
        buf_widx   = beat_q;
        buf_wdata  = pmem_wdata;
        buf_ridx   = beat_q;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        case (state_q)
            IDLE: begin
                line_d   = pmem_address[31:5];
                issued_d = '0;
                recvd_d  = '0;
                beat_d   = '0;
                if (pmem_write) begin
                    state_d = WR_COLLECT;
                end else if (pmem_read) begin
                    state_d = RD_FETCH;
                end
            end

            RD_FETCH: begin
                if (issued_q < LINE_WORDS) begin
                    mem_req  = 1'b1;
                    mem_addr = pmem_word_addr(line_q, issued_q[1:0]);
                    if (mem_gnt) begin
                        issued_d = issued_q + 3'd1;
                    end
                end
                // Returns arrive in order, so the receive count is the buffer slot.
                if (mem_rvalid && (recvd_q < LINE_WORDS)) begin
                    buf_we    = 1'b1;
                    buf_widx  = recvd_q[1:0];
                    buf_wdata = mem_rdata;
                    recvd_d   = recvd_q + 3'd1;
                end
                if (recvd_d == LINE_WORDS) begin
                    state_d = RD_RESP;
                end
            end

            RD_RESP: begin
                pmem_resp  = 1'b1;
                pmem_rdata = buf_rdata;
                beat_d     = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            WR_COLLECT: begin
                pmem_resp = 1'b1;
                buf_we    = 1'b1;
                buf_widx  = beat_q;
                buf_wdata = pmem_wdata;
                beat_d    = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = WR_DRAIN;
                end
            end

            WR_DRAIN: begin
                buf_ridx = issued_q[1:0];
                if (issued_q < LINE_WORDS) begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = pmem_word_addr(line_q, issued_q[1:0]);
                    mem_wdata = buf_rdata;
                    if (mem_gnt) begin
                        issued_d = issued_q + 3'd1;
                    end
                end
                // Posted write: the requester was released after the last beat.
                if (issued_d == LINE_WORDS) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            line_q   <= '0;
            issued_q <= '0;
            recvd_q  <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            line_q   <= line_d;
            issued_q <= issued_d;
            recvd_q  <= recvd_d;
            beat_q   <= beat_d;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_pmem_burst_bridge.sv
// Directed bench for pmem_burst_bridge with a req/gnt/rvalid backing memory
// model and an expected-transaction queue for backing-side ordering.
module tb_pmem_burst_bridge;
    import rv32i_types::*;

    logic               clk;
    logic               reset_n;
    logic               pmem_read;
    logic               pmem_write;
    logic [31:0]        pmem_address;
    logic [63:0]        pmem_wdata;
    logic               pmem_resp;
    logic [63:0]        pmem_rdata;
    logic               mem_req;
    logic               mem_we;
    logic [28:0]        mem_addr;
    logic [63:0]        mem_wdata;
    logic               mem_gnt;
    logic               mem_rvalid;
    logic [63:0]        mem_rdata;
    pmem_bridge_state_t dbg_state;

    pmem_burst_bridge #(.BURST_LEN(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- backing memory model ----------------
    logic [63:0] bmem [logic [28:0]];
    logic [93:0] exp_q[$];          // {we, word addr, wdata (0 for reads)}
    logic [28:0] pend_addr[$];
    int          pend_due[$];
    int          gnt_mode   = 0;    // 0: always, 1: random, 2: limited budget
    int          gnt_budget = 0;
    int          lat_min    = 1;
    int          lat_max    = 1;
    bit          keep_stale = 1'b0;
    int          last_due   = 0;
    int          last_rv_cyc = -100;
    int          n_wr_done  = 0;
    logic        prev_stall = 1'b0;
    logic [28:0] prev_addr;
    logic        prev_we;
    logic [63:0] prev_wdata;

    always @(negedge clk) begin
        logic [93:0] e;
        logic [28:0] a;
        int          due;
        if (!reset_n) begin
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            prev_stall = 1'b0;
            if (!keep_stale) begin
                pend_addr.delete();
                pend_due.delete();
            end
        end else begin
            if (prev_stall) begin
                check("hold_req",   mem_req,   1'b1);
                check("hold_addr",  mem_addr,  prev_addr);
                check("hold_we",    mem_we,    prev_we);
                check("hold_wdata", mem_wdata, prev_wdata);
            end
            case (gnt_mode)
                0:       mem_gnt = 1'b1;
                1:       mem_gnt = ($urandom_range(0, 1) == 1);
                default: mem_gnt = (gnt_budget > 0);
            endcase
            if (mem_req && mem_gnt) begin
                if (gnt_budget > 0) gnt_budget--;
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_txn", {mem_we, mem_addr}, 30'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_txn", {mem_we, mem_addr, (mem_we ? mem_wdata : 64'h0)}, e);
                end
                if (mem_we) begin
                    bmem[mem_addr] = mem_wdata;
                    n_wr_done++;
                end else begin
                    due = cyc + $urandom_range(lat_min, lat_max);
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    pend_addr.push_back(mem_addr);
                    pend_due.push_back(due);
                end
            end
            prev_stall = mem_req && !mem_gnt;
            prev_addr  = mem_addr;
            prev_we    = mem_we;
            prev_wdata = mem_wdata;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                void'(pend_due.pop_front());
                a = pend_addr.pop_front();
                mem_rvalid  = 1'b1;
                mem_rdata   = bmem.exists(a) ? bmem[a] : 64'hDEAD_DEAD_DEAD_DEAD;
                last_rv_cyc = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_read(input logic [31:0] addr, input logic [255:0] exp_line,
                           input bit pre, input bit chk_timing, input string tag);
        int t0, beat, guard, prev_cyc;
        logic [28:0] wa;
        wa = {addr[31:5], 2'b00};
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, wa + 29'(i), 64'h0});
        if (!pre) begin
            @(negedge clk);
            pmem_read    = 1'b1;
            pmem_address = addr;
        end
        t0 = cyc;
        check({tag, "_idle_at_req"}, dbg_state, IDLE);
        beat = 0; guard = 0; prev_cyc = 0;
        while (beat < 4 && guard < 300) begin
            @(negedge clk);
            guard++;
            if (pmem_resp) begin
                check($sformatf("%s_rdata%0d", tag, beat), pmem_rdata, exp_line[64*beat +: 64]);
                if (beat == 0) begin
                    check({tag, "_resp_after_last_rvalid"}, cyc, last_rv_cyc + 1);
                    if (chk_timing) check({tag, "_first_resp_cycle"}, cyc, t0 + 6);
                end else begin
                    check({tag, "_resp_consecutive"}, cyc, prev_cyc + 1);
                end
                prev_cyc = cyc;
                beat++;
            end
        end
        if (beat < 4) check({tag, "_timeout_beats"}, beat, 4);
        @(negedge clk);
        check({tag, "_done_state"}, dbg_state, DONE);
        check({tag, "_done_resp"}, pmem_resp, 1'b0);
        check({tag, "_done_rdata"}, pmem_rdata, 64'h0);
        if (chk_timing) check({tag, "_done_cycle"}, cyc, t0 + 10);
        pmem_read = 1'b0;
        @(negedge clk);
        check({tag, "_back_idle"}, dbg_state, IDLE);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [255:0] wl, input bit both,
                            input bit follow_read, input logic [31:0] raddr,
                            input bit chk_timing, input string tag);
        int t0, beat, guard, wr0, prev_cyc;
        logic [28:0] wa;
        wa = {addr[31:5], 2'b00};
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, wa + 29'(i), wl[64*i +: 64]});
        @(negedge clk);
        pmem_write   = 1'b1;
        pmem_read    = both;
        pmem_address = addr;
        pmem_wdata   = '0;
        t0 = cyc; wr0 = n_wr_done;
        beat = 0; guard = 0; prev_cyc = 0;
        while (beat < 4 && guard < 50) begin
            @(negedge clk);
            guard++;
            if (guard == 1) check({tag, "_collect_state"}, dbg_state, WR_COLLECT);
            if (pmem_resp) begin
                if (beat == 0) begin
                    if (chk_timing) check({tag, "_first_resp_cycle"}, cyc, t0 + 1);
                end else begin
                    check({tag, "_resp_consecutive"}, cyc, prev_cyc + 1);
                end
                pmem_wdata = wl[64*beat +: 64];
                prev_cyc = cyc;
                beat++;
            end
        end
        if (beat < 4) check({tag, "_timeout_beats"}, beat, 4);
        @(negedge clk);
        pmem_write   = 1'b0;
        pmem_read    = follow_read;
        pmem_address = raddr;
        pmem_wdata   = '0;
        guard = 0;
        while (dbg_state != IDLE && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_drained_at_idle"}, n_wr_done - wr0, 4);
        if (chk_timing) check({tag, "_idle_cycle"}, cyc, t0 + 9);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_resp"},  pmem_resp,  1'b0);
        check({tag, "_rdata"}, pmem_rdata, 64'h0);
        check({tag, "_req"},   mem_req,    1'b0);
        check({tag, "_we"},    mem_we,     1'b0);
        check({tag, "_addr"},  mem_addr,   29'h0);
        check({tag, "_wdata"}, mem_wdata,  64'h0);
        check({tag, "_state"}, dbg_state,  IDLE);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        reset_n = 1'b0; pmem_read = 1'b0; pmem_write = 1'b0;
        pmem_address = '0; pmem_wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        bmem[29'h208] = 64'h11; bmem[29'h209] = 64'h22;
        bmem[29'h20A] = 64'h33; bmem[29'h20B] = 64'h44;
        bmem[29'h400] = 64'h55; bmem[29'h401] = 64'h66;
        bmem[29'h402] = 64'h77; bmem[29'h403] = 64'h88;

        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        reset_n = 1'b1;

        // zero-stall read
        do_read(32'h0000_1040, {64'h44, 64'h33, 64'h22, 64'h11}, 1'b0, 1'b1, "rd_zero_stall");

        // random grant stalls and latency 1..7
        gnt_mode = 1; lat_min = 1; lat_max = 7;
        for (int i = 0; i < 3; i++)
            do_read(32'h0000_1040, {64'h44, 64'h33, 64'h22, 64'h11}, 1'b0, 1'b0, "rd_stall");

        // write then immediate read of the same line
        gnt_mode = 0; lat_min = 1; lat_max = 1;
        do_write(32'h8000_0020, {64'hA3, 64'hA2, 64'hA1, 64'hA0}, 1'b0, 1'b1,
                 32'h8000_0020, 1'b1, "wr");
        do_read(32'h8000_0020, {64'hA3, 64'hA2, 64'hA1, 64'hA0}, 1'b1, 1'b1, "rd_after_wr");

        // simultaneous read and write: write path
        do_write(32'h8000_0040, {64'hB3, 64'hB2, 64'hB1, 64'hB0}, 1'b1, 1'b0,
                 32'h0, 1'b1, "wr_both");

        // write drain under random stalls
        gnt_mode = 1;
        do_write(32'h8000_0060, {64'hC3, 64'hC2, 64'hC1, 64'hC0}, 1'b0, 1'b0,
                 32'h0, 1'b0, "wr_stall");
        gnt_mode = 0;
        do_read(32'h8000_0060, {64'hC3, 64'hC2, 64'hC1, 64'hC0}, 1'b0, 1'b1, "rd_wr_stall");

        // reset with two reads outstanding
        gnt_mode = 2; gnt_budget = 2; lat_min = 8; lat_max = 8; keep_stale = 1'b1;
        exp_q.push_back({1'b0, 29'h208, 64'h0});
        exp_q.push_back({1'b0, 29'h209, 64'h0});
        @(negedge clk);
        pmem_read = 1'b1; pmem_address = 32'h0000_1040; t0 = cyc;
        repeat (4) @(negedge clk);
        check("rst_mid_fetch_state", dbg_state, RD_FETCH);
        check("rst_outstanding", pend_due.size(), 2);
        #2;
        reset_n = 1'b0; pmem_read = 1'b0;
        #1;
        check_outputs_zero("rst_async");
        @(negedge clk);
        #2 reset_n = 1'b1;
        gnt_mode = 0; lat_min = 1; lat_max = 1;
        while (cyc < t0 + 12) @(negedge clk);
        check("rst_stale_returned", pend_due.size(), 0);
        check("rst_idle_after_stale", dbg_state, IDLE);
        keep_stale = 1'b0;
        do_read(32'h0000_2000, {64'h88, 64'h77, 64'h66, 64'h55}, 1'b0, 1'b1, "rd_post_rst");

        // low address bits ignored
        do_read(32'h0000_105C, {64'h44, 64'h33, 64'h22, 64'h11}, 1'b0, 1'b1, "rd_lowbits");

        repeat (3) @(negedge clk);
        check("sb_leftover", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
